// File: rtl/pipelined_branch_comparator.sv
// Two-stage pipelined RISC-V branch comparator: sliced lt/eq flags in stage 1, priority merge and funct3 decode in stage 2.
// Optional performance counters (perf_total, perf_taken) are enabled by defining CMP_PERF_CNT_EN.
module pipelined_branch_comparator #(
  parameter int WIDTH     = 32,
  parameter int CHUNKS    = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [2:0]           func3,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 compare_result,
  output logic                 illegal,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef CMP_PERF_CNT_EN
  ,
  output logic [31:0]          perf_total,
  output logic [31:0]          perf_taken
`endif
);

  localparam int SW = (WIDTH + CHUNKS - 1) / CHUNKS;
  localparam int PW = SW * CHUNKS;

  logic                 s1_valid;
  logic [CHUNKS-1:0]    s1_ult;
  logic [CHUNKS-1:0]    s1_eq;
  logic                 s1_sign1;
  logic                 s1_sign2;
  logic [2:0]           s1_func3;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic                 s2_valid;
  logic                 s2_result;
  logic                 s2_illegal;
  logic [TAG_WIDTH-1:0] s2_tag;

  logic                 s1_adv;
  logic                 s2_adv;
  logic                 accept;

  logic [PW-1:0]        pad1;
  logic [PW-1:0]        pad2;
  logic [CHUNKS-1:0]    ult_d;
  logic [CHUNKS-1:0]    eq_d;

  logic                 eq_all;
  logic                 ltu;
  logic                 lt;
  logic                 result_d;
  logic                 illegal_d;

  assign s2_adv   = s2_valid && out_ready;
  assign s1_adv   = s1_valid && (!s2_valid || s2_adv);
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  // Zero-extension pads the top slice; equal padding in both operands cannot change any flag.
  assign pad1 = PW'(data1);
  assign pad2 = PW'(data2);

  always_comb begin
    ult_d = '0;
    eq_d  = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      ult_d[i] = pad1[i*SW +: SW] <  pad2[i*SW +: SW];
      eq_d[i]  = pad1[i*SW +: SW] == pad2[i*SW +: SW];
    end
  end

  // The most significant differing slice decides the unsigned ordering.
  always_comb begin
    eq_all = &s1_eq;
    ltu    = 1'b0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (!s1_eq[i]) ltu = s1_ult[i];
    end
    lt = (s1_sign1 != s1_sign2) ? s1_sign1 : ltu;
  end

  always_comb begin
    result_d  = 1'b0;
    illegal_d = 1'b0;
    case (s1_func3)
      3'b000:  result_d = eq_all;
      3'b001:  result_d = !eq_all;
      3'b100:  result_d = lt;
      3'b101:  result_d = !lt;
      3'b110:  result_d = ltu;
      3'b111:  result_d = !ltu;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_ult     <= '0;
      s1_eq      <= '0;
      s1_sign1   <= 1'b0;
      s1_sign2   <= 1'b0;
      s1_func3   <= 3'b000;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= 1'b0;
      s2_illegal <= 1'b0;
      s2_tag     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (!s1_valid || s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_ult   <= ult_d;
        s1_eq    <= eq_d;
        s1_sign1 <= data1[WIDTH-1];
        s1_sign2 <= data2[WIDTH-1];
        s1_func3 <= func3;
        s1_tag   <= in_tag;
      end
      if (!s2_valid || s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_result  <= result_d;
        s2_illegal <= illegal_d;
        s2_tag     <= s1_tag;
      end
    end
  end

  assign out_valid      = s2_valid && !flush;
  assign compare_result = s2_result;
  assign illegal        = s2_illegal;
  assign out_tag        = s2_tag;

`ifdef CMP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total <= '0;
      perf_taken <= '0;
    end else if (out_valid && out_ready) begin
      perf_total <= perf_total + 32'd1;
      if (s2_result) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule
